// File: rtl/ethernet_packet_detector_pkg.sv
// -----------------------------------------------------------------------------
// ethernet_packet_detector_pkg
// Shared constants, FSM state encoding and field-check helpers for the
// byte-serial Ethernet frame checker.
// -----------------------------------------------------------------------------
package ethernet_packet_detector_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE       = 8'h55;
  localparam logic [7:0]  SFD_BYTE            = 8'hD5;
  localparam logic [2:0]  PREAMBLE_LEN        = 3'd7;
  localparam logic [47:0] DEFAULT_STATION_MAC = 48'h001A_2B3C_4D5E;
  localparam logic [47:0] BROADCAST_MAC       = 48'hFFFF_FFFF_FFFF;

  localparam int          SIZE_W        = 11;
  localparam logic [10:0] MIN_FRAME     = 11'd64;
  localparam logic [10:0] MAX_FRAME     = 11'd1518;
  localparam logic [10:0] SIZE_SAT      = 11'h7FF;
  localparam logic [15:0] MAX_LENGTH    = 16'd1500;
  localparam logic [15:0] MIN_ETHERTYPE = 16'h0600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_PAYLOAD,
    ST_DROP
  } state_e;

  // Destination accepted if it is our own address or broadcast.
  function automatic logic dst_match(input logic [47:0] mac,
                                     input logic [47:0] station);
    return (mac == station) || (mac == BROADCAST_MAC);
  endfunction

  // Source must be unicast (I/G bit of first wire byte clear) and non-zero.
  function automatic logic src_match(input logic [47:0] mac);
    return !mac[40] && (mac != 48'd0);
  endfunction

  // 802.3 length (<= 1500) or Ethernet II EtherType (>= 0x0600).
  function automatic logic type_match(input logic [15:0] tl);
    return (tl <= MAX_LENGTH) || (tl >= MIN_ETHERTYPE);
  endfunction

  function automatic logic size_match(input logic [10:0] size);
    return (size >= MIN_FRAME) && (size <= MAX_FRAME);
  endfunction

endpackage

// File: rtl/ethernet_packet_detector.sv
// -----------------------------------------------------------------------------
// ethernet_packet_detector
// Parses preamble/SFD, destination, source and type/length of a byte-serial
// receive stream, checks total frame size and counts fully valid frames.
//
// Ports
//   clk                   in   rising-edge clock
//   reset                 in   asynchronous active-high reset
//   data[7:0]             in   receive byte, qualified by control
//   control               in   1 = byte in frame, 0 = idle / end of frame
//   preamble_valid        out  7 x 0x55 + SFD seen
//   dst_addr_valid        out  destination is STATION_MAC or broadcast
//   src_addr_valid        out  source is unicast and non-zero
//   type_length_valid     out  type/length <= 1500 or >= 0x0600
//   packet_size_valid     out  dst..last byte within 64..1518
//   valid_packet_counter  out  wrapping count of fully valid frames
// -----------------------------------------------------------------------------
module ethernet_packet_detector
  import ethernet_packet_detector_pkg::*;
#(
  parameter logic [47:0] STATION_MAC = DEFAULT_STATION_MAC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       control,
  output logic       preamble_valid,
  output logic       dst_addr_valid,
  output logic       src_addr_valid,
  output logic       type_length_valid,
  output logic       packet_size_valid,
  output logic [3:0] valid_packet_counter
);

  state_e            state_q, state_d;
  logic [2:0]        pre_cnt_q, pre_cnt_d;
  logic [2:0]        field_cnt_q, field_cnt_d;
  logic [47:0]       shift_q, shift_d;
  logic [SIZE_W-1:0] size_q, size_d;

  logic       pre_ok_q, pre_ok_d;
  logic       dst_ok_q, dst_ok_d;
  logic       src_ok_q, src_ok_d;
  logic       type_ok_q, type_ok_d;
  logic       size_ok_q, size_ok_d;
  logic [3:0] vcnt_q, vcnt_d;

  // Field value including the byte being sampled this cycle, so the check
  // on the last byte of a field lands on the same edge that samples it.
  logic [47:0] field_word;
  logic        sfd_hit;
  logic        dst_last, src_last, type_last;
  logic [SIZE_W-1:0] size_inc;

  assign field_word = {shift_q[39:0], data};
  assign sfd_hit    = (data == SFD_BYTE) && (pre_cnt_q == PREAMBLE_LEN);
  assign dst_last   = (field_cnt_q == 3'd5);
  assign src_last   = (field_cnt_q == 3'd5);
  assign type_last  = (field_cnt_q == 3'd1);
  assign size_inc   = (size_q == SIZE_SAT) ? size_q : size_q + 11'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      field_cnt_q <= '0;
      shift_q     <= '0;
      size_q      <= '0;
      pre_ok_q    <= 1'b0;
      dst_ok_q    <= 1'b0;
      src_ok_q    <= 1'b0;
      type_ok_q   <= 1'b0;
      size_ok_q   <= 1'b0;
      vcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      field_cnt_q <= field_cnt_d;
      shift_q     <= shift_d;
      size_q      <= size_d;
      pre_ok_q    <= pre_ok_d;
      dst_ok_q    <= dst_ok_d;
      src_ok_q    <= src_ok_d;
      type_ok_q   <= type_ok_d;
      size_ok_q   <= size_ok_d;
      vcnt_q      <= vcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    field_cnt_d = field_cnt_q;
    shift_d     = shift_q;
    size_d      = size_q;

    unique case (state_q)
      ST_IDLE: begin
        if (control) begin
          size_d      = '0;
          field_cnt_d = '0;
          if (data == PREAMBLE_BYTE) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d   = ST_DROP;
            pre_cnt_d = '0;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!control) begin
          state_d = ST_IDLE;
        end else if ((data == PREAMBLE_BYTE) && (pre_cnt_q < PREAMBLE_LEN)) begin
          pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (sfd_hit) begin
          state_d     = ST_DST;
          field_cnt_d = '0;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DST: begin
        if (!control) begin
          state_d = ST_IDLE;
        end else begin
          shift_d = field_word;
          size_d  = size_inc;
          if (dst_last) begin
            field_cnt_d = '0;
            state_d     = dst_match(field_word, STATION_MAC) ? ST_SRC : ST_DROP;
          end else begin
            field_cnt_d = field_cnt_q + 3'd1;
          end
        end
      end

      ST_SRC: begin
        if (!control) begin
          state_d = ST_IDLE;
        end else begin
          shift_d = field_word;
          size_d  = size_inc;
          if (src_last) begin
            field_cnt_d = '0;
            state_d     = src_match(field_word) ? ST_TYPE : ST_DROP;
          end else begin
            field_cnt_d = field_cnt_q + 3'd1;
          end
        end
      end

      ST_TYPE: begin
        if (!control) begin
          state_d = ST_IDLE;
        end else begin
          shift_d = field_word;
          size_d  = size_inc;
          if (type_last) begin
            field_cnt_d = '0;
            state_d     = type_match(field_word[15:0]) ? ST_PAYLOAD : ST_DROP;
          end else begin
            field_cnt_d = field_cnt_q + 3'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!control) state_d = ST_IDLE;
        else          size_d  = size_inc;
      end

      ST_DROP: begin
        if (!control) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered flag and counter updates
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_ok_d  = pre_ok_q;
    dst_ok_d  = dst_ok_q;
    src_ok_d  = src_ok_q;
    type_ok_d = type_ok_q;
    size_ok_d = size_ok_q;
    vcnt_d    = vcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Flags from the previous frame are held until the next one starts.
        if (control) begin
          pre_ok_d  = 1'b0;
          dst_ok_d  = 1'b0;
          src_ok_d  = 1'b0;
          type_ok_d = 1'b0;
          size_ok_d = 1'b0;
        end
      end
      ST_PREAMBLE: if (control && sfd_hit) pre_ok_d = 1'b1;
      ST_DST: begin
        if (control && dst_last && dst_match(field_word, STATION_MAC))
          dst_ok_d = 1'b1;
      end
      ST_SRC: begin
        if (control && src_last && src_match(field_word)) src_ok_d = 1'b1;
      end
      ST_TYPE: begin
        if (control && type_last && type_match(field_word[15:0]))
          type_ok_d = 1'b1;
      end
      ST_PAYLOAD: begin
        if (!control) begin
          size_ok_d = size_match(size_q);
          if (size_match(size_q) && pre_ok_q && dst_ok_q && src_ok_q && type_ok_q)
            vcnt_d = vcnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign preamble_valid       = pre_ok_q;
  assign dst_addr_valid       = dst_ok_q;
  assign src_addr_valid       = src_ok_q;
  assign type_length_valid    = type_ok_q;
  assign packet_size_valid    = size_ok_q;
  assign valid_packet_counter = vcnt_q;

endmodule

// File: tb/tb_ethernet_packet_detector.sv
// -----------------------------------------------------------------------------
// tb_ethernet_packet_detector
// Scenario tasks drive whole frames; the expected end-of-frame result is
// computed from the frame bytes by a reference model, queued when the frame
// is driven and popped when the frame-end edge has been sampled.
// -----------------------------------------------------------------------------
module tb_ethernet_packet_detector;

  localparam logic [47:0] STATION = 48'h001A_2B3C_4D5E;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_OK  = 48'h0011_2233_4455;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic       pre;
    logic       dst;
    logic       src;
    logic       typ;
    logic       size;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       control;
  logic       preamble_valid, dst_addr_valid, src_addr_valid;
  logic       type_length_valid, packet_size_valid;
  logic [3:0] valid_packet_counter;

  int   total = 0;
  int   bad   = 0;
  logic [3:0] exp_cnt = '0;
  exp_t sb[$];

  ethernet_packet_detector dut (
    .clk                  (clk),
    .reset                (reset),
    .data                 (data),
    .control              (control),
    .preamble_valid       (preamble_valid),
    .dst_addr_valid       (dst_addr_valid),
    .src_addr_valid       (src_addr_valid),
    .type_length_valid    (type_length_valid),
    .packet_size_valid    (packet_size_valid),
    .valid_packet_counter (valid_packet_counter)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    return {preamble_valid, dst_addr_valid, src_addr_valid,
            type_length_valid, packet_size_valid, valid_packet_counter};
  endfunction

  // Reference model: result after the first n bytes of frame f; 'ended'
  // means the following cycle had control=0.
  function automatic exp_t predict(byte_q_t f, int n, bit ended, logic [3:0] cnt);
    exp_t        e;
    logic [47:0] mac;
    logic [15:0] tl;
    int          sz;
    e = '0;
    if (n >= 8) begin
      e.pre = (f[7] == 8'hD5);
      for (int i = 0; i < 7; i++) if (f[i] != 8'h55) e.pre = 1'b0;
    end
    if (e.pre && n >= 14) begin
      mac = '0;
      for (int i = 8; i < 14; i++) mac = {mac[39:0], f[i]};
      e.dst = (mac == STATION) || (mac == BCAST);
    end
    if (e.dst && n >= 20) begin
      mac = '0;
      for (int i = 14; i < 20; i++) mac = {mac[39:0], f[i]};
      e.src = (f[14][0] == 1'b0) && (mac != 48'd0);
    end
    if (e.src && n >= 22) begin
      tl    = {f[20], f[21]};
      e.typ = (tl <= 16'd1500) || (tl >= 16'h0600);
    end
    sz = n - 8;
    if (sz > 2047) sz = 2047;
    e.size = ended && e.typ && (sz >= 64) && (sz <= 1518);
    e.cnt  = e.size ? cnt + 4'd1 : cnt;
    return e;
  endfunction

  // size = bytes from first dst byte to last byte
  function automatic byte_q_t build_frame(logic [47:0] dst, logic [47:0] src,
                                          logic [15:0] tl, int size);
    byte_q_t f;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) f.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) f.push_back(src[i*8 +: 8]);
    f.push_back(tl[15:8]);
    f.push_back(tl[7:0]);
    for (int i = 0; i < size - 14; i++) f.push_back(8'(i + 8'h30));
    return f;
  endfunction

  task automatic send_frame(input byte_q_t f, input bit trace, input string name);
    exp_t e, got;
    e = predict(f, f.size(), 1'b1, exp_cnt);
    sb.push_back(e);
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      data    = f[i];
      control = 1'b1;
      if (trace) begin
        @(posedge clk);
        #1;
        e   = predict(f, i + 1, 1'b0, exp_cnt);
        got = observed();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL %s byte%0d: got=%b need=%b", name, i, got, e);
        end
      end
    end
    @(negedge clk);
    control = 1'b0;
    data    = 8'h00;
    @(posedge clk);
    #1;
    e       = sb.pop_front();
    exp_cnt = e.cnt;
    got     = observed();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s end: got=%b need=%b", name, got, e);
    end
  endtask

  task automatic apply_reset();
    exp_t got;
    reset   = 1'b1;
    control = 1'b0;
    data    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    got = observed();
    total++;
    if (got !== exp_t'(0)) begin
      bad++;
      $display("FAIL reset: got=%b need=%b", got, exp_t'(0));
    end
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_valid_64();
    send_frame(build_frame(STATION, SRC_OK, 16'h0800, 64), 1'b1, "valid64");
  endtask

  task automatic test_size_bounds();
    send_frame(build_frame(BCAST, SRC_OK, 16'h002E, 1518), 1'b0, "size1518");
    send_frame(build_frame(BCAST, SRC_OK, 16'h002E, 1519), 1'b0, "size1519");
    send_frame(build_frame(STATION, SRC_OK, 16'h0800, 63), 1'b0, "size63");
    send_frame(build_frame(STATION, SRC_OK, 16'h0800, 2100), 1'b0, "size2100");
  endtask

  task automatic test_bad_preamble();
    byte_q_t f;
    f    = build_frame(STATION, SRC_OK, 16'h0800, 64);
    f[5] = 8'h54;
    send_frame(f, 1'b1, "badpre");
    f    = build_frame(STATION, SRC_OK, 16'h0800, 64);
    f[7] = 8'h55;
    send_frame(f, 1'b0, "nosfd");
    send_frame(build_frame(48'h001A_2B3C_4D5F, SRC_OK, 16'h0800, 64), 1'b0, "baddst");
  endtask

  task automatic test_src_type();
    send_frame(build_frame(STATION, 48'h0111_2233_4455, 16'h0800, 64), 1'b1, "mcastsrc");
    send_frame(build_frame(STATION, 48'h0, 16'h0800, 64), 1'b0, "zerosrc");
    send_frame(build_frame(STATION, SRC_OK, 16'h05EE, 64), 1'b1, "type05EE");
    send_frame(build_frame(STATION, SRC_OK, 16'd1500, 64), 1'b0, "type1500");
    send_frame(build_frame(STATION, SRC_OK, 16'd1501, 64), 1'b0, "type1501");
    send_frame(build_frame(STATION, SRC_OK, 16'h05FF, 64), 1'b0, "type05FF");
    send_frame(build_frame(STATION, SRC_OK, 16'h0600, 64), 1'b0, "type0600");
  endtask

  task automatic test_truncated();
    byte_q_t f;
    f = build_frame(STATION, SRC_OK, 16'h0800, 64);
    while (f.size() > 21) void'(f.pop_back());
    send_frame(f, 1'b0, "trunc_type");
    f = build_frame(STATION, SRC_OK, 16'h0800, 64);
    while (f.size() > 10) void'(f.pop_back());
    send_frame(f, 1'b0, "trunc_dst");
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t f;
    exp_t    got;
    f = build_frame(STATION, SRC_OK, 16'h0800, 64);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      data    = f[i];
      control = 1'b1;
    end
    @(posedge clk);
    #1;
    total++;
    if (preamble_valid !== 1'b1 || valid_packet_counter !== exp_cnt) begin
      bad++;
      $display("FAIL pre_reset: got=%b/%0d need=1/%0d",
               preamble_valid, valid_packet_counter, exp_cnt);
    end
    #2;
    reset   = 1'b1;
    control = 1'b0;
    #1;
    got = observed();
    total++;
    if (got !== exp_t'(0)) begin
      bad++;
      $display("FAIL async_reset: got=%b need=%b", got, exp_t'(0));
    end
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = '0;
    send_frame(build_frame(STATION, SRC_OK, 16'h0800, 64), 1'b1, "post_reset");
  endtask

  task automatic test_back_to_back_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++)
      send_frame(build_frame((i % 2) ? BCAST : STATION, SRC_OK, 16'h0800, 64 + i),
                 1'b0, $sformatf("wrap%0d", i));
    total++;
    if (valid_packet_counter !== 4'd1) begin
      bad++;
      $display("FAIL wrap_count: got=%0d need=1", valid_packet_counter);
    end
  endtask

  initial begin
    reset   = 1'b1;
    control = 1'b0;
    data    = 8'h00;
    test_reset();
    test_valid_64();
    test_size_bounds();
    test_bad_preamble();
    test_src_type();
    test_truncated();
    test_reset_mid_frame();
    test_back_to_back_wrap();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left: got=%0d need=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
